// File: rtl/multicycle_ctrl_if.sv
// Shared memory-port handshake between the multi-cycle controller and memory.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle RV32I-subset datapath: fetch/decode/exec/mem/wb
// over one memory port, with retired-instruction counter and trap on bad opcode or stalled memory.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      ir,
  input  logic             alu_zero,
  multicycle_ctrl_if.master mem,
  output logic             pc_we,
  output logic             pc_src,
  output logic             ir_we,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             trap,
  output logic [1:0]       trap_cause
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  localparam logic [6:0]  OP_R      = 7'b0110011;
  localparam logic [6:0]  OP_I      = 7'b0010011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [15:0] LIMIT     = MEM_TIMEOUT[15:0];

  state_t             r_state, w_next;
  logic [15:0]        r_wait;
  logic [CNT_W-1:0]   r_instret;
  logic [1:0]         r_trap_cause, w_cause_next;
  logic [6:0]         w_opcode;
  logic               w_legal, w_timeout, w_is_store;

  assign w_opcode   = ir[6:0];
  assign w_is_store = (w_opcode == OP_STORE);
  assign w_legal    = (w_opcode == OP_R) || (w_opcode == OP_I) || (w_opcode == OP_LOAD) ||
                      w_is_store || (w_opcode == OP_JAL) ||
                      ((w_opcode == OP_BRANCH) && (ir[14:13] == 2'b00));
  // Limit check uses the pre-increment count, so a ready on the limit cycle still completes.
  assign w_timeout  = (MEM_TIMEOUT != 0) && (r_wait == LIMIT) && !mem.mem_ready;

  assign instret    = r_instret;
  assign trap_cause = r_trap_cause;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_wait       <= '0;
      r_instret    <= '0;
      r_trap_cause <= '0;
    end else begin
      r_state      <= w_next;
      r_trap_cause <= w_cause_next;
      if (retire)
        r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
      if (mem.mem_req && !mem.mem_ready && (w_next == r_state))
        r_wait <= (r_wait == '1) ? r_wait : r_wait + 16'd1;
      else
        r_wait <= '0;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_cause_next = r_trap_cause;
    case (r_state)
      IDLE:   w_next = FETCH;
      FETCH: begin
        if (mem.mem_ready) w_next = DECODE;
        else if (w_timeout) begin
          w_next       = TRAP;
          w_cause_next = 2'd2;
        end
      end
      DECODE: begin
        if (w_legal) w_next = EXEC;
        else begin
          w_next       = TRAP;
          w_cause_next = 2'd1;
        end
      end
      EXEC: begin
        case (w_opcode)
          OP_R, OP_I:          w_next = WB;
          OP_LOAD, OP_STORE:   w_next = MEM;
          OP_BRANCH, OP_JAL:   w_next = FETCH;
          default: begin
            w_next       = TRAP;
            w_cause_next = 2'd1;
          end
        endcase
      end
      MEM: begin
        if (mem.mem_ready) w_next = w_is_store ? FETCH : WB;
        else if (w_timeout) begin
          w_next       = TRAP;
          w_cause_next = 2'd2;
        end
      end
      WB:     w_next = FETCH;
      TRAP:   w_next = TRAP;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    pc_we            = 1'b0;
    pc_src           = 1'b0;
    ir_we            = 1'b0;
    reg_we           = 1'b0;
    wb_sel           = 2'd0;
    alu_src_a        = 2'd0;
    alu_src_b        = 2'd0;
    alu_op           = 2'd0;
    retire           = 1'b0;
    trap             = 1'b0;
    mem.mem_req      = 1'b0;
    mem.mem_we       = 1'b0;
    mem.mem_addr_sel = 1'b0;
    case (r_state)
      FETCH: begin
        mem.mem_req = 1'b1;
        alu_src_a   = 2'd1;
        alu_src_b   = 2'd2;
        ir_we       = mem.mem_ready;
        pc_we       = mem.mem_ready;
      end
      DECODE: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
      end
      EXEC: begin
        case (w_opcode)
          OP_R:              alu_op = 2'd2;
          OP_I: begin
            alu_src_b = 2'd1;
            alu_op    = 2'd2;
          end
          OP_LOAD, OP_STORE: alu_src_b = 2'd1;
          OP_BRANCH: begin
            alu_op = 2'd1;
            pc_src = 1'b1;
            pc_we  = ir[12] ? !alu_zero : alu_zero;
            retire = 1'b1;
          end
          OP_JAL: begin
            pc_we  = 1'b1;
            pc_src = 1'b1;
            reg_we = 1'b1;
            wb_sel = 2'd2;
            retire = 1'b1;
          end
          default: ;
        endcase
      end
      MEM: begin
        mem.mem_req      = 1'b1;
        mem.mem_addr_sel = 1'b1;
        mem.mem_we       = w_is_store;
        retire           = w_is_store && mem.mem_ready;
      end
      WB: begin
        reg_we = 1'b1;
        wb_sel = (w_opcode == OP_LOAD) ? 2'd1 : 2'd0;
        retire = 1'b1;
      end
      TRAP:    trap = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl plus hand-written trap/timeout/reset sequences.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pc_we, pc_src, ir_we, mem_req, mem_we, mem_addr_sel, reg_we;
    logic [1:0] wb_sel, a, b, op;
    logic       retire;
  } out_t;

  typedef struct {
    logic [31:0] ir;
    logic        zero;
    out_t        exp;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] ir = '0;
  logic        alu_zero = 1'b0;
  logic        pc_we, pc_src, ir_we, reg_we, retire, trap;
  logic [1:0]  wb_sel, alu_src_a, alu_src_b, alu_op, trap_cause;
  logic [31:0] instret;
  int unsigned checks = 0;
  int unsigned errors = 0;
  vec_t        vecs[$];

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .ir(ir), .alu_zero(alu_zero), .mem(bus),
    .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .reg_we(reg_we), .wb_sel(wb_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .retire(retire),
    .instret(instret), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic out_t mk(input logic pcwe, pcsrc, irwe, req, we, asel, rwe,
                              input logic [1:0] wb, a, b, op, input logic ret);
    out_t o;
    o = '{pcwe, pcsrc, irwe, req, we, asel, rwe, wb, a, b, op, ret};
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o = '{pc_we, pc_src, ir_we, bus.mem_req, bus.mem_we, bus.mem_addr_sel, reg_we,
          wb_sel, alu_src_a, alu_src_b, alu_op, retire};
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] i, input logic z, input out_t e, input string n);
    vec_t v;
    v.ir = i; v.zero = z; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  // Leaves reset released two time units after a negedge, FSM in IDLE.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    out_t O_IDLE, O_FETCH, O_DEC, O_EX_IMM;
    int unsigned bad;
    O_IDLE   = mk(0,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0);
    O_FETCH  = mk(1,0,1,1,0,0,0, 2'd0,2'd1,2'd2,2'd0, 0);
    O_DEC    = mk(0,0,0,0,0,0,0, 2'd0,2'd2,2'd1,2'd0, 0);
    O_EX_IMM = mk(0,0,0,0,0,0,0, 2'd0,2'd0,2'd1,2'd0, 0);

    add(32'h00108113, 0, O_IDLE,  "idle");
    add(32'h00108113, 0, O_FETCH, "addi_fetch");
    add(32'h00108113, 0, O_DEC,   "addi_decode");
    add(32'h00108113, 0, mk(0,0,0,0,0,0,0, 2'd0,2'd0,2'd1,2'd2, 0), "addi_exec");
    add(32'h00108113, 0, mk(0,0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0, 1), "addi_wb");
    add(32'hFFF0A103, 0, O_FETCH, "lw_fetch");
    add(32'hFFF0A103, 0, O_DEC,   "lw_decode");
    add(32'hFFF0A103, 0, O_EX_IMM, "lw_exec");
    add(32'hFFF0A103, 0, mk(0,0,0,1,0,1,0, 2'd0,2'd0,2'd0,2'd0, 0), "lw_mem");
    add(32'hFFF0A103, 0, mk(0,0,0,0,0,0,1, 2'd1,2'd0,2'd0,2'd0, 1), "lw_wb");
    add(32'hFE20AFA3, 0, O_FETCH, "sw_fetch");
    add(32'hFE20AFA3, 0, O_DEC,   "sw_decode");
    add(32'hFE20AFA3, 0, O_EX_IMM, "sw_exec");
    add(32'hFE20AFA3, 0, mk(0,0,0,1,1,1,0, 2'd0,2'd0,2'd0,2'd0, 1), "sw_mem");
    add(32'hFE208FE3, 1, O_FETCH, "beq_t_fetch");
    add(32'hFE208FE3, 1, O_DEC,   "beq_t_decode");
    add(32'hFE208FE3, 1, mk(1,1,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd1, 1), "beq_taken");
    add(32'hFE208FE3, 0, O_FETCH, "beq_n_fetch");
    add(32'hFE208FE3, 0, O_DEC,   "beq_n_decode");
    add(32'hFE208FE3, 0, mk(0,1,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd1, 1), "beq_not_taken");
    add(32'h008000EF, 0, O_FETCH, "jal_fetch");
    add(32'h008000EF, 0, O_DEC,   "jal_decode");
    add(32'h008000EF, 0, mk(1,1,0,0,0,0,1, 2'd2,2'd0,2'd0,2'd0, 1), "jal_exec");
    add(32'hFE209FE3, 0, O_FETCH, "bne_fetch");
    add(32'hFE209FE3, 0, O_DEC,   "bne_decode");
    add(32'hFE209FE3, 0, mk(1,1,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd1, 1), "bne_taken");

    // Reset state
    bus.mem_ready = 1'b1;
    #1;
    chk("reset_outputs", 64'(sample()), 64'(O_IDLE));
    chk("reset_instret", 64'(instret), 64'd0);
    chk("reset_trap", 64'({trap, trap_cause}), 64'd0);

    // Table-driven sequence with memory always ready
    do_reset();
    foreach (vecs[k]) begin
      ir = vecs[k].ir;
      alu_zero = vecs[k].zero;
      #1;
      chk(vecs[k].name, 64'(sample()), 64'(vecs[k].exp));
      @(negedge clk);
    end
    chk("instret_after_table", 64'(instret), 64'd7);

    // Illegal opcode traps after DECODE and stays quiet
    do_reset();
    ir = 32'h0000007F;
    repeat (3) @(negedge clk);
    #1;
    chk("illegal_trap", 64'({trap, trap_cause}), 64'({1'b1, 2'd1}));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mem_req || pc_we || reg_we || ir_we || !trap) bad++;
    end
    chk("trap_hold_20", 64'(bad), 64'd0);
    do_reset();
    #1;
    chk("trap_cleared_by_reset", 64'({trap, trap_cause, bus.mem_req}), 64'd0);

    // Fetch timeout: 16th stalled FETCH cycle without ready traps
    do_reset();
    ir = 32'h00108113;
    bus.mem_ready = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    chk("timeout_not_yet", 64'({trap, bus.mem_req}), 64'({1'b0, 1'b1}));
    @(posedge clk);
    #1;
    chk("timeout_trap", 64'({trap, trap_cause, bus.mem_req}), 64'({1'b1, 2'd2, 1'b0}));

    // Ready arriving on the limit cycle wins
    do_reset();
    bus.mem_ready = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    bus.mem_ready = 1'b1;
    #1;
    chk("limit_ready_irwe", 64'(ir_we), 64'd1);
    @(posedge clk);
    #1;
    chk("limit_ready_decode", 64'({trap, alu_src_a}), 64'({1'b0, 2'd2}));

    // Asynchronous reset while a load waits in MEM
    do_reset();
    ir = 32'hFFF0A103;
    bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("mem_wait_req", 64'({bus.mem_req, bus.mem_addr_sel}), 64'({1'b1, 1'b1}));
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_drop", 64'({bus.mem_req, reg_we, retire}), 64'd0);
    chk("async_reset_instret", 64'(instret), 64'd0);
    reset_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
